// File: rtl/pong_game_engine.sv
// -----------------------------------------------------------------------------
// pong_game_engine
//   Game-state engine for a two-player Pong renderer. Holds both paddle rows,
//   the ball position and direction, the scores and the match state machine.
//   All motion is committed on frame_tick (issued in vertical blank), so the
//   positions are stable for the whole visible frame. The per-pixel hit flags
//   are purely combinational from (x, y) and the registered positions.
//
// Ports
//   clk, reset          system clock, synchronous active-low reset
//   x, y                current pixel column / row from the sync generator
//   frame_tick          one-cycle pulse per frame
//   start               level; starts the match, or restarts it after a win
//   p1_up/p1_down       paddle 1 (left) controls, sampled on frame_tick
//   p2_up/p2_down       paddle 2 (right) controls, sampled on frame_tick
//   pad1_on/pad2_on     pixel lies inside paddle 1 / paddle 2
//   ball_on             pixel lies inside the ball
//   winner              00 idle, 01 serving/playing, 10 player 1 won, 11 player 2 won
//   score1/score2       player points
// -----------------------------------------------------------------------------
module pong_game_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD1_X       = 32,
  parameter int PAD2_X       = 600,
  parameter int BALL_SZ      = 8,
  parameter int BALL_SPD     = 2,
  parameter int PAD_SPD      = 4,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic       pad1_on,
  output logic       pad2_on,
  output logic       ball_on,
  output logic [1:0] winner,
  output logic [3:0] score1,
  output logic [3:0] score2
);

  // 10-bit copies of the geometry so every comparison is width-matched.
  localparam logic [9:0] HA      = 10'(H_ACTIVE);
  localparam logic [9:0] VA      = 10'(V_ACTIVE);
  localparam logic [9:0] PH      = 10'(PAD_H);
  localparam logic [9:0] PW      = 10'(PAD_W);
  localparam logic [9:0] P1X     = 10'(PAD1_X);
  localparam logic [9:0] P2X     = 10'(PAD2_X);
  localparam logic [9:0] P1R     = 10'(PAD1_X + PAD_W);   // paddle 1 face
  localparam logic [9:0] BSZ     = 10'(BALL_SZ);
  localparam logic [9:0] BSPD    = 10'(BALL_SPD);
  localparam logic [9:0] PSPD    = 10'(PAD_SPD);
  localparam logic [9:0] PAD_MAX = 10'(V_ACTIVE - PAD_H);
  localparam logic [9:0] PAD_Y0  = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] BALL_X0 = 10'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0 = 10'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);

  localparam int         CW         = $clog2(SERVE_FRAMES);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_RUN  = 2'b01;
  localparam logic [1:0] W_P1   = 2'b10;
  localparam logic [1:0] W_P2   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_P1_WIN,
    S_P2_WIN
  } state_t;

  state_t        state;
  logic [9:0]    pad1_y, pad2_y, ball_x, ball_y;
  logic          dx;   // 1 = moving right
  logic          dy;   // 1 = moving down
  logic [CW-1:0] serve_cnt;

  // ---------------------------------------------------------------------------
  // Per-pixel hit flags (half-open rectangles, zero latency)
  // ---------------------------------------------------------------------------
  assign pad1_on = (x >= P1X) && (x < P1X + PW) && (y >= pad1_y) && (y < pad1_y + PH);
  assign pad2_on = (x >= P2X) && (x < P2X + PW) && (y >= pad2_y) && (y < pad2_y + PH);
  assign ball_on = (x >= ball_x) && (x < ball_x + BSZ) &&
                   (y >= ball_y) && (y < ball_y + BSZ);

  // Saturating paddle step; the up case tests before subtracting so the
  // unsigned row never wraps.
  function automatic logic [9:0] pad_next(input logic [9:0] py,
                                          input logic up, input logic dn);
    if (up && !dn)      return (py < PSPD) ? 10'd0 : py - PSPD;
    else if (dn && !up) return (py > PAD_MAX - PSPD) ? PAD_MAX : py + PSPD;
    else                return py;
  endfunction

  // ---------------------------------------------------------------------------
  // Ball step for one PLAY frame
  // ---------------------------------------------------------------------------
  logic [9:0] nx_ball_x, nx_ball_y, step_l, step_r;
  logic       nx_dx, nx_dy, over1, over2, miss_l, miss_r;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    nx_ball_y = ball_y;
    nx_ball_x = ball_x;
    nx_dx     = dx;
    nx_dy     = dy;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
    step_l    = ball_x - BSPD;
    step_r    = ball_x + BSPD;
    over1     = (ball_y + BSZ > pad1_y) && (ball_y < pad1_y + PH);
    over2     = (ball_y + BSZ > pad2_y) && (ball_y < pad2_y + PH);

    // Vertical motion is independent of the horizontal outcome, so a wall
    // bounce and a paddle hit in the same frame both take effect.
    if (!dy) begin
      if (ball_y <= BSPD) begin
        nx_ball_y = 10'd0;
        nx_dy     = 1'b1;
      end else begin
        nx_ball_y = ball_y - BSPD;
      end
    end else begin
      if (ball_y + BSZ + BSPD >= VA) begin
        nx_ball_y = VA - BSZ;
        nx_dy     = 1'b0;
      end else begin
        nx_ball_y = ball_y + BSPD;
      end
    end

    // Horizontal: a paddle hit requires the ball to cross the paddle face
    // this frame, so a ball already behind the paddle cannot be returned.
    if (!dx && ball_x >= P1R && step_l <= P1R && over1) begin
      nx_ball_x = P1R;
      nx_dx     = 1'b1;
    end else if (dx && ball_x + BSZ <= P2X && step_r + BSZ >= P2X && over2) begin
      nx_ball_x = P2X - BSZ;
      nx_dx     = 1'b0;
    end else if (!dx && ball_x <= BSPD) begin
      miss_l = 1'b1;
    end else if (dx && ball_x + BSZ + BSPD >= HA) begin
      miss_r = 1'b1;
    end else begin
      nx_ball_x = dx ? step_r : step_l;
    end
  end

  // ---------------------------------------------------------------------------
  // Match state machine and game state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      winner    <= W_IDLE;
      score1    <= '0;
      score2    <= '0;
      pad1_y    <= PAD_Y0;
      pad2_y    <= PAD_Y0;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= '0;
    end else begin
      unique case (state)
        // Start is honoured on any cycle here, not only on frame_tick.
        S_IDLE: begin
          if (start) begin
            state     <= S_SERVE;
            winner    <= W_RUN;
            score1    <= '0;
            score2    <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            serve_cnt <= '0;
          end
        end

        S_SERVE: begin
          if (frame_tick) begin
            pad1_y <= pad_next(pad1_y, p1_up, p1_down);
            pad2_y <= pad_next(pad2_y, p2_up, p2_down);
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            if (serve_cnt == SERVE_LAST) begin
              state     <= S_PLAY;
              serve_cnt <= '0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end

        S_PLAY: begin
          if (frame_tick) begin
            pad1_y <= pad_next(pad1_y, p1_up, p1_down);
            pad2_y <= pad_next(pad2_y, p2_up, p2_down);
            dy     <= nx_dy;
            if (miss_l || miss_r) begin
              ball_x    <= BALL_X0;
              ball_y    <= BALL_Y0;
              serve_cnt <= '0;
              if (miss_l) begin
                score2 <= score2 + 4'd1;
                if (score2 + 4'd1 == WIN) begin
                  state  <= S_P2_WIN;
                  winner <= W_P2;
                end else begin
                  state <= S_SERVE;
                  dx    <= 1'b0;   // serve toward the player who conceded
                end
              end else begin
                score1 <= score1 + 4'd1;
                if (score1 + 4'd1 == WIN) begin
                  state  <= S_P1_WIN;
                  winner <= W_P1;
                end else begin
                  state <= S_SERVE;
                  dx    <= 1'b1;
                end
              end
            end else begin
              ball_x <= nx_ball_x;
              ball_y <= nx_ball_y;
              dx     <= nx_dx;
            end
          end
        end

        // Everything frozen until a restart on a frame boundary.
        S_P1_WIN, S_P2_WIN: begin
          if (frame_tick && start) begin
            state     <= S_SERVE;
            winner    <= W_RUN;
            score1    <= '0;
            score2    <= '0;
            dx        <= 1'b1;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            serve_cnt <= '0;
          end
        end

        default: begin
          state  <= S_IDLE;
          winner <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_game_engine
//   Scoreboard bench for pong_game_engine. The stimulus thread plays a scripted
//   game, parks the pixel probe (x, y) at hand-computed coordinates and queues
//   the expected value of one output; the monitor samples on the falling edge
//   whenever a probe is presented and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_pong_game_engine;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [9:0] x, y;
  logic       pad1_on, pad2_on, ball_on;
  logic [1:0] winner;
  logic [3:0] score1, score2;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .start      (start),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .pad1_on    (pad1_on),
    .pad2_on    (pad2_on),
    .ball_on    (ball_on),
    .winner     (winner),
    .score1     (score1),
    .score2     (score2)
  );

  typedef enum {SEL_BALL, SEL_PAD1, SEL_PAD2, SEL_WIN, SEL_S1, SEL_S2} sel_t;

  typedef struct {
    string name;
    sel_t  sel;
    int    value;
  } exp_t;

  exp_t exp_q[$];
  logic probe_req = 1'b0;
  int   total  = 0;
  int   passed = 0;

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per presented probe
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (probe_req) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL probe_without_expectation at x=%0d y=%0d", x, y);
      end else begin
        e = exp_q.pop_front();
        case (e.sel)
          SEL_BALL: act = int'(ball_on);
          SEL_PAD1: act = int'(pad1_on);
          SEL_PAD2: act = int'(pad2_on);
          SEL_WIN:  act = int'(winner);
          SEL_S1:   act = int'(score1);
          default:  act = int'(score2);
        endcase
        if (act == e.value) passed++;
        else $display("FAIL %s (x=%0d y=%0d): got %0d, expected %0d",
                      e.name, x, y, act, e.value);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input sel_t sel,
                       input int px, input int py, input int value);
    exp_t e;
    @(posedge clk); #1;
    x = 10'(px);
    y = 10'(py);
    e.name  = name;
    e.sel   = sel;
    e.value = value;
    exp_q.push_back(e);
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  // One frame_tick pulse per frame, frames four clocks long.
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scripted game
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state and rectangle boundaries
    check("rst_winner",     SEL_WIN,  0,   0,   0);
    check("rst_score1",     SEL_S1,   0,   0,   0);
    check("rst_score2",     SEL_S2,   0,   0,   0);
    check("rst_ball_in",    SEL_BALL, 316, 236, 1);
    check("rst_ball_right", SEL_BALL, 324, 236, 0);
    check("rst_ball_left",  SEL_BALL, 315, 236, 0);
    check("rst_ball_bot",   SEL_BALL, 316, 244, 0);
    check("rst_pad1_in",    SEL_PAD1, 32,  208, 1);
    check("rst_pad1_xedge", SEL_PAD1, 40,  208, 0);
    check("rst_pad1_last",  SEL_PAD1, 39,  271, 1);
    check("rst_pad1_yedge", SEL_PAD1, 32,  272, 0);
    check("rst_pad2_in",    SEL_PAD2, 600, 208, 1);
    check("rst_pad2_left",  SEL_PAD2, 599, 208, 0);

    // Paddles stay put while idle
    p1_up = 1'b1;
    ticks(3);
    p1_up = 1'b0;
    check("idle_pad1_hold", SEL_PAD1, 32, 207, 0);
    check("idle_winner",    SEL_WIN,  0,  0,   0);

    // Serve: 60 frames at centre, paddles driven into both clamps
    pulse_start();
    check("serve_winner", SEL_WIN, 0, 0, 1);
    p1_up = 1'b1; p2_down = 1'b1;
    ticks(59);
    check("serve_59_ball", SEL_BALL, 316, 236, 1);
    ticks(1);
    check("serve_60_ball",  SEL_BALL, 316, 236, 1);
    check("serve_60_win",   SEL_WIN,  0,   0,   1);
    check("pad1_top_clamp", SEL_PAD1, 32,  0,   1);
    check("pad1_top_end",   SEL_PAD1, 32,  64,  0);
    check("pad2_bot_clamp", SEL_PAD2, 600, 479, 1);
    check("pad2_bot_start", SEL_PAD2, 600, 415, 0);
    p1_up = 1'b0; p2_down = 1'b0;
    ticks(1);                                   // play frame 1
    check("play1_ball",      SEL_BALL, 318, 238, 1);
    check("play1_ball_left", SEL_BALL, 317, 238, 0);

    // Bottom wall bounce
    ticks(116);                                 // frame 117
    check("f117_ball",      SEL_BALL, 550, 470, 1);
    ticks(1);                                   // frame 118: clamp to 472
    check("wall_clamp",     SEL_BALL, 552, 479, 1);
    check("wall_clamp_top", SEL_BALL, 552, 471, 0);
    ticks(1);                                   // frame 119: heading up
    check("wall_up",        SEL_BALL, 554, 470, 1);
    check("wall_up_bot",    SEL_BALL, 554, 478, 0);

    // Paddle 2 return (pad2 at 416 overlaps ball row 434)
    ticks(19);                                  // frame 138
    check("pad2_hit_pos",   SEL_BALL, 592, 432, 1);
    ticks(1);                                   // frame 139: moving left
    check("pad2_ret_left",  SEL_BALL, 590, 430, 1);
    check("pad2_ret_right", SEL_BALL, 598, 430, 0);

    // Move paddle 1 down to row 108, then both buttons hold it
    p1_down = 1'b1;
    ticks(27);                                  // frame 166
    p1_down = 1'b0;
    check("pad1_at_108",    SEL_PAD1, 32, 108, 1);
    check("pad1_above_108", SEL_PAD1, 32, 107, 0);
    p1_up = 1'b1; p1_down = 1'b1;
    ticks(10);                                  // frame 176
    p1_up = 1'b0; p1_down = 1'b0;
    check("pad1_both_top",  SEL_PAD1, 32, 107, 0);
    check("pad1_both_last", SEL_PAD1, 32, 171, 1);
    check("pad1_both_end",  SEL_PAD1, 32, 172, 0);

    // Top wall bounce
    ticks(178);                                 // frame 354
    check("top_wall",      SEL_BALL, 160, 0, 1);
    check("top_wall_left", SEL_BALL, 159, 0, 0);

    // Paddle 1 return: ball at x=42, row pad1_y+10
    ticks(59);                                  // frame 413
    check("pre_hit1",      SEL_BALL, 42, 118, 1);
    check("pre_hit1_left", SEL_BALL, 41, 118, 0);
    ticks(1);                                   // frame 414
    check("hit1_face",      SEL_BALL, 40, 120, 1);
    check("hit1_face_left", SEL_BALL, 39, 120, 0);
    ticks(1);                                   // frame 415: heading right
    check("hit1_right",      SEL_BALL, 42, 122, 1);
    check("hit1_right_left", SEL_BALL, 41, 122, 0);

    // Reset in the middle of a rally
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    check("mid_rst_winner", SEL_WIN,  0,   0,   0);
    check("mid_rst_ball",   SEL_BALL, 316, 236, 1);
    check("mid_rst_pad1",   SEL_PAD1, 32,  207, 0);
    check("mid_rst_pad2",   SEL_PAD2, 600, 208, 1);

    // Match: paddle 2 parked at 208, every rally misses on the right after
    // 60 serve frames + 158 play frames
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      ticks(217);
      check($sformatf("pre_point%0d_s1", k), SEL_S1, 0, 0, k - 1);
      ticks(1);
      check($sformatf("point%0d_s1", k),  SEL_S1,  0, 0, k);
      check($sformatf("point%0d_win", k), SEL_WIN, 0, 0, (k < 5) ? 1 : 2);
    end
    check("match_s2", SEL_S2, 0, 0, 0);

    // Frozen after the win
    p1_up = 1'b1; p2_up = 1'b1;
    ticks(5);
    p1_up = 1'b0; p2_up = 1'b0;
    check("frozen_ball", SEL_BALL, 316, 236, 1);
    check("frozen_pad1", SEL_PAD1, 32,  207, 0);
    check("frozen_pad2", SEL_PAD2, 600, 271, 1);
    check("frozen_win",  SEL_WIN,  0,   0,   2);
    check("frozen_s1",   SEL_S1,   0,   0,   5);

    // Restart from the win; first play frame must move right
    start = 1'b1;
    ticks(1);
    start = 1'b0;
    check("restart_win", SEL_WIN, 0, 0, 1);
    check("restart_s1",  SEL_S1,  0, 0, 0);
    check("restart_s2",  SEL_S2,  0, 0, 0);
    ticks(61);
    check("restart_dx",      SEL_BALL, 318, 236, 1);
    check("restart_dx_left", SEL_BALL, 317, 236, 0);

    // Drain and report
    repeat (4) @(posedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      $display("FAIL %s: never sampled, expected %0d", e.name, e.value);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
